// File: rtl/seq_mult_pkg.sv
// Shared types for the shift-and-add multiplier.
// The FSM state encoding and iteration-counter sizing live here.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_multiplier_add_nbit.sv
// Ripple adder with carry-out used for the per-iteration add step.
// It is the N-bit generalisation of the half-adder cell.
module add_nbit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] full;

    assign full = {1'b0, x} + {1'b0, y};
    assign sum  = full[WIDTH-1:0];
    assign cout = full[WIDTH];

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier with start/busy/done handshake.
// Define MULT_SIGNED_EN for two's-complement operands and product.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int CW = cnt_w(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nx;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   a_ld;
    logic [WIDTH-1:0]   b_ld;
    logic               cout;
    logic               accept;
    logic               last;

    assign accept = start && (state != CALC);
    assign busy   = (state == CALC);
    assign addend = acc[0] ? mcand : '0;
    assign last   = (cnt == CW'(WIDTH - 1));

    add_nbit #(
        .WIDTH(WIDTH)
    ) u_add (
        .x   (acc[2*WIDTH-1:WIDTH]),
        .y   (addend),
        .sum (sum),
        .cout(cout)
    );

    // Carry re-enters at the top as the accumulator shifts right.
    assign acc_nx = {cout, sum, acc[WIDTH-1:1]};

`ifdef MULT_SIGNED_EN
    logic sign;

    // Magnitudes fit in WIDTH unsigned bits, including -2^(W-1).
    assign a_ld = a[WIDTH-1] ? -a : a;
    assign b_ld = b[WIDTH-1] ? -b : b;
    assign prod = sign ? -acc_nx : acc_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign <= 1'b0;
        end else if (accept) begin
            sign <= a[WIDTH-1] ^ b[WIDTH-1];
        end
    end
`else
    assign a_ld = a;
    assign b_ld = b;
    assign prod = acc_nx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
            p     <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                CALC: begin
                    acc <= acc_nx;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state <= DONE;
                        p     <= prod;
                        done  <= 1'b1;
                    end
                end
                IDLE, DONE: begin
                    if (accept) begin
                        state <= CALC;
                        mcand <= a_ld;
                        acc   <= {{WIDTH{1'b0}}, b_ld};
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=8.
// Signed vectors run only when MULT_SIGNED_EN is defined.
module tb_seq_multiplier;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;

    int n_cmp = 0;
    int n_err = 0;

    seq_multiplier #(
        .WIDTH(W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .p    (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and wait for done; reports latency and busy cycles.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int lat, output int nbusy);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        nbusy = 0;
        while (!done && lat < 20) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int nb;
        int k;
        int seen;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_p", p, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);

        run_op(8'd13, 8'd11, lat, nb);
        chk("13x11_lat", lat, 8);
        chk("13x11_busy", nb, 8);
        chk("13x11_p", p, 16'h008F);
        @(negedge clk);
        chk("13x11_done_1cyc", done, 0);
        chk("13x11_hold", p, 16'h008F);

`ifndef MULT_SIGNED_EN
        run_op(8'd255, 8'd255, lat, nb);
        chk("255x255_p", p, 16'hFE01);
`endif
        run_op(8'd0, 8'd200, lat, nb);
        chk("0x200_done", done, 1);
        chk("0x200_p", p, 0);

        // Start held through DONE: second op must follow with no idle gap.
        @(negedge clk);
        start = 1'b1;
        a     = 8'd3;
        b     = 8'd7;
        @(negedge clk);
        a = 8'd5;
        b = 8'd5;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_first_lat", lat, 8);
        chk("b2b_first_p", p, 21);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_no_gap_busy", busy, 1);
        k = 1;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_period", k, 9);
        chk("b2b_second_p", p, 25);

        // Mid-CALC start pulses and operand changes are ignored.
        @(negedge clk);
        start = 1'b1;
        a     = 8'd13;
        b     = 8'd11;
        @(negedge clk);
        start = 1'b0;
        a     = 8'd200;
        b     = 8'd200;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 8'd99;
        lat   = 3;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("midcalc_lat", lat, 8);
        chk("midcalc_p", p, 16'h008F);
        @(negedge clk);
        chk("midcalc_not_queued", busy, 0);

        // Reset during the 4th iteration.
        @(negedge clk);
        start = 1'b1;
        a     = 8'd9;
        b     = 8'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("prerst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_p", p, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("postrst_quiet", seen, 0);
        run_op(8'd6, 8'd7, lat, nb);
        chk("postrst_lat", lat, 8);
        chk("postrst_p", p, 42);

`ifdef MULT_SIGNED_EN
        run_op(8'hFD, 8'd5, lat, nb);
        chk("s_m3x5", p, 16'hFFF1);
        run_op(8'h80, 8'h80, lat, nb);
        chk("s_m128xm128", p, 16'h4000);
        run_op(8'd127, 8'h80, lat, nb);
        chk("s_127xm128", p, 16'hC080);
        chk("s_lat", lat, 8);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
